prog_counter: RTL and testbench
===============================

// Module: prog_counter
// PURPOSE
//  Parametrised up/down counter with synchronous clear, parallel load, and modulo limit.
//  Modes: wrap, saturate, one-shot. Flags: terminal count, busy, done.
//  Shared timebase/event-counting block; replaces fixed 8-bit free-running counters.
// PARAMETERS
//  WIDTH      8              counter width in bits (>=2)
//  MAX_VAL    2**WIDTH-1     upper terminal value, inclusive; 0 < MAX_VAL <= 2**WIDTH-1
//  RESET_VAL  0              count value after reset/clr; must be <= MAX_VAL
// PORTS
//  clk       in   1      clock, rising edge
//  rst_n     in   1      synchronous active-low reset
//  en        in   1      count enable; one step per cycle while high
//  clr       in   1      synchronous clear to RESET_VAL
//  load      in   1      parallel load strobe
//  load_val  in   WIDTH  load value
//  dir       in   1      1 = up, 0 = down
//  mode      in   2      prog_counter_pkg::mode_e: 00 WRAP, 01 SAT, 10 ONESHOT, 11 = WRAP
//  start     in   1      one-shot arm/restart strobe
//  count     out  WIDTH  current count, registered
//  tc        out  1      terminal-count pulse, registered
//  busy      out  1      one-shot running
//  done      out  1      one-shot finished; sticky
// BEHAVIOUR
//  - Reset (rst_n=0 at clk edge): count=RESET_VAL, tc=0, busy=0, done=0, FSM=IDLE.
//  - Per-cycle priority: rst_n > clr > load > start > en step.
//  - clr: count=RESET_VAL, tc=0, FSM=IDLE.
//  - load: count=min(load_val, MAX_VAL); FSM=IDLE; no step that cycle.
//  - Terminal value: MAX_VAL when dir=1; 0 when dir=0.
//  - "At terminal" = an enabled step is taken while count == terminal value.
//  - WRAP: up MAX_VAL->0; down 0->MAX_VAL.
//  - SAT: count holds at the terminal value.
//  - Otherwise count +/-1. Compute in WIDTH+1 bits; no silent overflow past MAX_VAL.
//  - tc=1 for exactly the one cycle after each at-terminal step, else 0.
//  - SAT: tc re-pulses on every enabled cycle spent at terminal.
//  - FSM (ONESHOT only), states IDLE/RUN/DONE:
//    - IDLE: en ignored, count holds. start -> RUN; count unchanged.
//    - RUN: busy=1; steps on en. At-terminal step -> DONE; count holds; tc pulses.
//    - DONE: done=1, count frozen, en ignored.
//      start -> RUN with count = 0 (dir=1) or MAX_VAL (dir=0).
//      clr/load -> IDLE.
//  - mode leaves ONESHOT: FSM -> IDLE same edge; busy/done drop next cycle.
//  - In WRAP/SAT: busy=0, done=0, start ignored.
//  - dir change takes effect on the next step; start and en same cycle in IDLE: start only.
//  - Latency: every input affects outputs at the next clk edge. No combinational in->out path.
// CONFIGURATION
//  PROG_COUNTER_STEP_EN defined:
//    - Adds input port step [WIDTH-1:0]. Each enabled step moves by step; step=0 holds.
//    - WRAP: result is (count +/- step) mod (MAX_VAL+1).
//    - SAT/ONESHOT: result clamps at the terminal value; clamp counts as at-terminal.
//  PROG_COUNTER_STEP_EN undefined: no step port; step fixed to 1.
// STRUCTURE
//  - prog_counter_pkg: mode_e (MODE_WRAP, MODE_SAT, MODE_ONESHOT); state_e (ST_IDLE, ST_RUN, ST_DONE).
//  - Sub-module prog_counter_next: combinational next-value + at_terminal flag.
//    Inputs: count, dir, mode, step. Parameters: WIDTH, MAX_VAL.
//  - Top: priority mux, FSM, registered count/tc/busy/done.
// TESTING (WIDTH=4, MAX_VAL=9, RESET_VAL=0)
//  1. WRAP up, en=1 for 12 cycles -> count 1..9,0,1,2; tc high only the cycle after 9->0.
//  2. SAT down from load_val=2, en=1 for 4 cycles -> count 1,0,0,0; tc high cycles 3 and 4.
//  3. load_val=15 -> count=9. Same cycle clr=1 and load=1 -> count=0.
//  4. ONESHOT up from 7: start, then en=1 x4 -> busy=1, count 8,9 (stop), done=1, tc once.
//     start again -> count=0, busy=1.
//  5. rst_n=0 for one cycle mid-RUN at count=5 -> next cycle count=0, busy=0, done=0, tc=0.
//  6. STEP_EN, WRAP up, step=4 from 8 -> count 2; SAT up step=4 from 8 -> count 9, tc=1.

Source files
------------

// File: rtl/prog_counter_pkg.sv
// Shared types for the programmable counter: counting modes and one-shot FSM states.
package prog_counter_pkg;

    // Encoding 2'b11 has no name of its own and behaves as MODE_WRAP.
    typedef enum logic [1:0] {
        MODE_WRAP    = 2'b00,
        MODE_SAT     = 2'b01,
        MODE_ONESHOT = 2'b10
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

endpackage

// File: rtl/prog_counter_next.sv
// Combinational next-value generator for prog_counter.
// Computes count +/- step in WIDTH+1 bits so a step past MAX_VAL is always
// caught. The count either wraps modulo MAX_VAL+1 or clamps at the terminal
// value. at_terminal is raised when the step starts from the terminal value,
// and in the clamping modes also when the step is cut short by the clamp.
module prog_counter_next
    import prog_counter_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int MAX_VAL = 2**WIDTH - 1
) (
    input  logic [WIDTH-1:0] count,
    input  logic             dir,
    input  mode_e            mode,
    input  logic [WIDTH-1:0] step,
    output logic [WIDTH-1:0] next_count,
    output logic             at_terminal
);

    localparam int XW = WIDTH + 1;
    localparam logic [XW-1:0]    MAX_X = XW'(MAX_VAL);
    localparam logic [XW-1:0]    MOD_X = MAX_X + 1'b1;
    localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_VAL);

    logic [XW-1:0] count_x;
    logic [XW-1:0] step_x;
    logic [XW-1:0] sum_x;
    logic [XW-1:0] diff_x;
    logic [XW-1:0] rem_x;
    logic          clamp;

    assign count_x = {1'b0, count};
    assign step_x  = {1'b0, step};
    assign clamp   = (mode == MODE_SAT) || (mode == MODE_ONESHOT);

    // Next count and terminal detection for one enabled step.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        next_count  = count;
        at_terminal = 1'b0;
        sum_x       = '0;
        diff_x      = '0;
        rem_x       = '0;
        if (dir) begin
            sum_x       = count_x + step_x;
            at_terminal = (count == MAX_W);
            if (sum_x > MAX_X) begin
                if (clamp) begin
                    next_count  = MAX_W;
                    at_terminal = 1'b1;
                end else begin
                    rem_x      = sum_x % MOD_X;
                    next_count = rem_x[WIDTH-1:0];
                end
            end else begin
                next_count = sum_x[WIDTH-1:0];
            end
        end else begin
            at_terminal = (count == '0);
            if (step_x > count_x) begin
                if (clamp) begin
                    next_count  = '0;
                    at_terminal = 1'b1;
                end else begin
                    diff_x = step_x - count_x;
                    rem_x  = diff_x % MOD_X;
                    sum_x  = MOD_X - rem_x;
                    next_count = (rem_x == '0) ? '0 : sum_x[WIDTH-1:0];
                end
            end else begin
                diff_x     = count_x - step_x;
                next_count = diff_x[WIDTH-1:0];
            end
        end
    end

endmodule

// File: rtl/prog_counter.sv
// Programmable up/down counter with clear, load, modulo limit and
// wrap / saturate / one-shot modes. Every output is a register.
// Optional feature macro: PROG_COUNTER_STEP_EN adds a 'step' input that sets
// the step size. Without it, the counter always steps by 1.
module prog_counter
    import prog_counter_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int MAX_VAL   = 2**WIDTH - 1,
    parameter int RESET_VAL = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dir,
    input  mode_e            mode,
    input  logic             start,
`ifdef PROG_COUNTER_STEP_EN
    input  logic [WIDTH-1:0] step,
`endif
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             busy,
    output logic             done
);

    localparam logic [WIDTH-1:0] MAX_W   = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] RESET_W = WIDTH'(RESET_VAL);
    localparam logic [WIDTH:0]   MAX_X   = (WIDTH+1)'(MAX_VAL);

    state_e           state;
    logic [WIDTH-1:0] step_size;
    logic [WIDTH-1:0] next_count;
    logic             at_terminal;
    logic [WIDTH-1:0] load_clamped;
    logic [WIDTH-1:0] restart_val;

`ifdef PROG_COUNTER_STEP_EN
    assign step_size = step;
`else
    assign step_size = WIDTH'(1);
`endif

    // A load value above MAX_VAL is clamped to MAX_VAL.
    assign load_clamped = ({1'b0, load_val} > MAX_X) ? MAX_W : load_val;
    // A one-shot restart begins at the far end from the terminal value.
    assign restart_val  = dir ? '0 : MAX_W;

    prog_counter_next #(
        .WIDTH   (WIDTH),
        .MAX_VAL (MAX_VAL)
    ) u_next (
        .count       (count),
        .dir         (dir),
        .mode        (mode),
        .step        (step_size),
        .next_count  (next_count),
        .at_terminal (at_terminal)
    );

    // Priority: reset > clr > load > start > en. Holds the one-shot FSM and the registered outputs.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so all registers update together.
        if (!rst_n) begin
            count <= RESET_W;
            tc    <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            state <= ST_IDLE;
        end else begin
            tc <= 1'b0;
            if (clr) begin
                count <= RESET_W;
                state <= ST_IDLE;
                busy  <= 1'b0;
                done  <= 1'b0;
            end else if (load) begin
                count <= load_clamped;
                state <= ST_IDLE;
                busy  <= 1'b0;
                done  <= 1'b0;
            end else if (mode != MODE_ONESHOT) begin
                state <= ST_IDLE;
                busy  <= 1'b0;
                done  <= 1'b0;
                if (en) begin
                    count <= next_count;
                    tc    <= at_terminal;
                end
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (start) begin
                            state <= ST_RUN;
                            busy  <= 1'b1;
                        end
                    end
                    ST_RUN: begin
                        if (start) begin
                            count <= restart_val;
                        end else if (en) begin
                            count <= next_count;
                            tc    <= at_terminal;
                            if (at_terminal) begin
                                state <= ST_DONE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end
                        end
                    end
                    ST_DONE: begin
                        if (start) begin
                            count <= restart_val;
                            state <= ST_RUN;
                            busy  <= 1'b1;
                            done  <= 1'b0;
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_prog_counter.sv
// Scoreboard bench for prog_counter with WIDTH=4, MAX_VAL=9, RESET_VAL=0.
// The driver applies inputs on the falling edge and queues the values it
// expects after the next rising edge. A monitor compares them #1 after that edge.
// Builds with PROG_COUNTER_STEP_EN defined also exercise the step port.
module tb_prog_counter;
    import prog_counter_pkg::*;

    localparam int W = 4;
    localparam logic [3:0] ALL = 4'b1111;  // mask bits: {count, tc, busy, done}
    localparam logic [3:0] CT  = 4'b1100;

    typedef struct {
        string      name;
        logic [3:0] mask;
        logic [W-1:0] count;
        logic       tc;
        logic       busy;
        logic       done;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n, en, clr, load, dir, start;
    logic [W-1:0] load_val;
    mode_e        mode;
`ifdef PROG_COUNTER_STEP_EN
    logic [W-1:0] step;
`endif
    logic [W-1:0] count;
    logic         tc, busy, done;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    prog_counter #(
        .WIDTH     (W),
        .MAX_VAL   (9),
        .RESET_VAL (0)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .clr      (clr),
        .load     (load),
        .load_val (load_val),
        .dir      (dir),
        .mode     (mode),
        .start    (start),
`ifdef PROG_COUNTER_STEP_EN
        .step     (step),
`endif
        .count    (count),
        .tc       (tc),
        .busy     (busy),
        .done     (done)
    );

    task automatic check(input exp_t e);
        logic bad;
        bad = 1'b0;
        if (e.mask[3] && count !== e.count) bad = 1'b1;
        if (e.mask[2] && tc    !== e.tc)    bad = 1'b1;
        if (e.mask[1] && busy  !== e.busy)  bad = 1'b1;
        if (e.mask[0] && done  !== e.done)  bad = 1'b1;
        checks++;
        if (bad) begin
            failures++;
            $display("FAIL %s: got count=%0d tc=%0b busy=%0b done=%0b, expected count=%0d tc=%0b busy=%0b done=%0b (mask %b)",
                     e.name, count, tc, busy, done, e.count, e.tc, e.busy, e.done, e.mask);
        end
    endtask

    // Monitor: one queued expectation per rising edge, sampled just after it.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check(e);
            end
        end
    end

    // Queue the expectation for the current inputs, then move to the next falling edge.
    task automatic cyc(input string name, input logic [3:0] mask, input int c,
                       input logic t, input logic b, input logic d);
        exp_t e;
        e.name  = name;
        e.mask  = mask;
        e.count = W'(c);
        e.tc    = t;
        e.busy  = b;
        e.done  = d;
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        en = 1'b0; clr = 1'b0; load = 1'b0; start = 1'b0;
    endtask

    initial begin
        int waited;
        rst_n = 1'b0; en = 1'b0; clr = 1'b0; load = 1'b0; load_val = '0;
        dir = 1'b1; mode = MODE_WRAP; start = 1'b0;
`ifdef PROG_COUNTER_STEP_EN
        step = 4'd1;
`endif
        @(negedge clk);
        cyc("reset", ALL, 0, 0, 0, 0);
        rst_n = 1'b1;

        // WRAP up for 12 cycles: 1..9, 0, 1, 2; tc only after 9->0.
        en = 1'b1;
        for (int i = 1; i <= 12; i++) cyc($sformatf("wrap_up_%0d", i), ALL, i % 10, i == 10, 0, 0);

        // SAT down from 2: 1, 0, 0, 0; tc on the 3rd and 4th steps.
        idle_inputs(); mode = MODE_SAT; dir = 1'b0; load = 1'b1; load_val = 4'd2;
        cyc("sat_load", ALL, 2, 0, 0, 0);
        idle_inputs(); en = 1'b1;
        cyc("sat_dn_1", ALL, 1, 0, 0, 0);
        cyc("sat_dn_2", ALL, 0, 0, 0, 0);
        cyc("sat_dn_3", ALL, 0, 1, 0, 0);
        cyc("sat_dn_4", ALL, 0, 1, 0, 0);
        idle_inputs();
        cyc("sat_hold", ALL, 0, 0, 0, 0);

        // Load clamp, then clr beats load in the same cycle.
        load = 1'b1; load_val = 4'd15;
        cyc("load_clamp", ALL, 9, 0, 0, 0);
        clr = 1'b1; load_val = 4'd5;
        cyc("clr_over_load", ALL, 0, 0, 0, 0);

        // Mode 2'b11 behaves as WRAP: up from 9 wraps to 0 with tc.
        idle_inputs(); load = 1'b1; load_val = 4'd9; dir = 1'b1;
        cyc("load_9", ALL, 9, 0, 0, 0);
        idle_inputs(); en = 1'b1; mode = mode_e'(2'b11);
        cyc("mode3_wrap", ALL, 0, 1, 0, 0);

        // ONESHOT up from 7.
        idle_inputs(); mode = MODE_ONESHOT; load = 1'b1; load_val = 4'd7;
        cyc("os_load", ALL, 7, 0, 0, 0);
        idle_inputs(); en = 1'b1;
        cyc("os_idle_en", ALL, 7, 0, 0, 0);
        start = 1'b1;
        cyc("os_start_en", ALL, 7, 0, 1, 0);
        start = 1'b0;
        cyc("os_run_8", ALL, 8, 0, 1, 0);
        cyc("os_run_9", ALL, 9, 0, 1, 0);
        cyc("os_term", ALL, 9, 1, 0, 1);
        cyc("os_done_frozen", ALL, 9, 0, 0, 1);
        en = 1'b0; start = 1'b1;
        cyc("os_restart", ALL, 0, 0, 1, 0);
        start = 1'b0; en = 1'b1;
        for (int i = 1; i <= 5; i++) cyc($sformatf("os_run2_%0d", i), ALL, i, 0, 1, 0);

        // Reset in the middle of a run.
        rst_n = 1'b0;
        cyc("rst_mid_run", ALL, 0, 0, 0, 0);
        rst_n = 1'b1;
        cyc("post_rst_idle", ALL, 0, 0, 0, 0);

        // ONESHOT down: terminal at 0, restart from DONE reloads MAX_VAL.
        idle_inputs(); dir = 1'b0; load = 1'b1; load_val = 4'd1;
        cyc("osd_load", ALL, 1, 0, 0, 0);
        load = 1'b0; start = 1'b1;
        cyc("osd_start", ALL, 1, 0, 1, 0);
        start = 1'b0; en = 1'b1;
        cyc("osd_0", ALL, 0, 0, 1, 0);
        cyc("osd_term", ALL, 0, 1, 0, 1);
        en = 1'b0; start = 1'b1;
        cyc("osd_restart", ALL, 9, 0, 1, 0);
        start = 1'b0; mode = MODE_WRAP;
        cyc("leave_oneshot", ALL, 9, 0, 0, 0);

`ifdef PROG_COUNTER_STEP_EN
        // Step of 4: WRAP 8 -> 2; SAT 8 clamps to 9 and pulses tc.
        idle_inputs(); dir = 1'b1; step = 4'd4; load = 1'b1; load_val = 4'd8;
        cyc("step_load_a", CT, 8, 0, 0, 0);
        idle_inputs(); en = 1'b1;
        cyc("step_wrap", CT, 2, 0, 0, 0);
        idle_inputs(); mode = MODE_SAT; load = 1'b1; load_val = 4'd8;
        cyc("step_load_b", CT, 8, 0, 0, 0);
        idle_inputs(); en = 1'b1;
        cyc("step_sat", CT, 9, 1, 0, 0);
        step = 4'd0;
        cyc("step_zero", CT, 9, 1, 0, 0);
`endif

        idle_inputs();
        waited = 0;
        while (exp_q.size() > 0 && waited < 5) begin
            @(negedge clk);
            waited++;
        end
        if (exp_q.size() > 0) begin
            failures++;
            $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
